// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared speed encodings, rate constants, divider helper and FSM state types
package i2c_pkg;

   typedef enum logic [1:0] {
      SPD_STD       = 2'b00,
      SPD_FAST      = 2'b01,
      SPD_FAST_PLUS = 2'b10,
      SPD_HIGH      = 2'b11
   } speed_t;

   localparam int unsigned SYS_CLK_HZ = 100_000_000;
   localparam int unsigned RATE_STD   = 100_000;
   localparam int unsigned RATE_FAST  = 400_000;
   localparam int unsigned RATE_FASTP = 1_000_000;
   localparam int unsigned RATE_HIGH  = 3_400_000;

   // One SCL period is four quarters; the count truncates toward zero.
   function automatic logic [15:0] quarter_count(input int unsigned sys_clk, input int unsigned rate);
      return 16'(sys_clk / (4 * rate));
   endfunction

   typedef enum logic [3:0] {
      M_IDLE, M_START, M_ADDR, M_ADDR_ACK, M_WDATA, M_WACK, M_RDATA, M_MNACK, M_STOP
   } m_state_t;

   typedef enum logic [2:0] {
      SL_IDLE, SL_ADDR, SL_ADDR_ACK, SL_WDATA, SL_WDATA_ACK, SL_RDATA, SL_RDATA_ACK, SL_IGNORE
   } slv_state_t;

endpackage

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - address-programmable single-byte I2C slave sampling the shared bus
module i2c_slave
   import i2c_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda,
   input  logic [6:0] addr_slv,
   input  logic [7:0] data_rd_slv,
   output logic [7:0] data_wr_slv,
   output logic       done_slv,
   output logic       sda_drv
);

   slv_state_t state;
   logic       scl_q;
   logic       sda_q;
   logic [6:0] shreg;
   logic [3:0] bit_cnt;
   logic       rw;
   logic       ack_on;

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   assign scl_rise  = scl & ~scl_q;
   assign scl_fall  = ~scl & scl_q;
   assign start_det = scl & scl_q & sda_q & ~sda;
   assign stop_det  = scl & scl_q & ~sda_q & sda;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= SL_IDLE;
         scl_q       <= 1'b1;
         sda_q       <= 1'b1;
         shreg       <= '0;
         bit_cnt     <= '0;
         rw          <= 1'b0;
         ack_on      <= 1'b0;
         data_wr_slv <= '0;
         done_slv    <= 1'b0;
         sda_drv     <= 1'b1;
      end else begin
         scl_q    <= scl;
         sda_q    <= sda;
         done_slv <= 1'b0;
         if (start_det) begin
            state   <= SL_ADDR;
            bit_cnt <= '0;
            ack_on  <= 1'b0;
            sda_drv <= 1'b1;
         end else if (stop_det) begin
            state   <= SL_IDLE;
            sda_drv <= 1'b1;
         end else begin
            case (state)
               SL_ADDR: if (scl_rise) begin
                  shreg   <= {shreg[5:0], sda};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     rw    <= sda;
                     state <= (shreg == addr_slv) ? SL_ADDR_ACK : SL_IGNORE;
                  end
               end
               // First fall opens the ACK bit, second fall closes it.
               SL_ADDR_ACK: if (scl_fall) begin
                  if (!ack_on) begin
                     sda_drv <= 1'b0;
                     ack_on  <= 1'b1;
                  end else begin
                     ack_on  <= 1'b0;
                     bit_cnt <= '0;
                     if (rw) begin
                        shreg   <= data_rd_slv[6:0];
                        sda_drv <= data_rd_slv[7];
                        state   <= SL_RDATA;
                     end else begin
                        sda_drv <= 1'b1;
                        state   <= SL_WDATA;
                     end
                  end
               end
               SL_WDATA: if (scl_rise) begin
                  shreg   <= {shreg[5:0], sda};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     data_wr_slv <= {shreg, sda};
                     done_slv    <= 1'b1;
                     state       <= SL_WDATA_ACK;
                  end
               end
               SL_WDATA_ACK: if (scl_fall) begin
                  if (!ack_on) begin
                     sda_drv <= 1'b0;
                     ack_on  <= 1'b1;
                  end else begin
                     ack_on  <= 1'b0;
                     sda_drv <= 1'b1;
                     bit_cnt <= '0;
                     state   <= SL_WDATA;
                  end
               end
               SL_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_drv <= 1'b1;
                        state   <= SL_RDATA_ACK;
                     end else begin
                        sda_drv <= shreg[6];
                        shreg   <= {shreg[5:0], 1'b0};
                     end
                  end
               end
               // A master ACK re-enters the closing half of the ACK bit to reload the next byte.
               SL_RDATA_ACK: if (scl_rise) begin
                  done_slv <= 1'b1;
                  if (sda) begin
                     state <= SL_IGNORE;
                  end else begin
                     ack_on <= 1'b1;
                     state  <= SL_ADDR_ACK;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/i2c_test.sv
// rtl/i2c_test.sv - I2C master, SCL divider and wired-AND bus with two loopback slaves
module i2c_test
   import i2c_pkg::*;
#(
   parameter int unsigned SYS_CLK    = SYS_CLK_HZ,
   parameter int unsigned DATA_RATE0 = RATE_STD,
   parameter int unsigned DATA_RATE1 = RATE_FAST,
   parameter int unsigned DATA_RATE2 = RATE_FASTP,
   parameter int unsigned DATA_RATE3 = RATE_HIGH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       write,
   input  logic       read,
   input  logic [1:0] speed_mode,
   input  logic [6:0] addr,
   input  logic [7:0] data_wr,
   output logic [7:0] data_rd,
   output logic       done,
   output logic       ack_error,
   output logic [7:0] data_wr_slv1,
   input  logic [7:0] data_rd_slv1,
   input  logic [6:0] addr_slv1,
   output logic       done_slv1,
   output logic [7:0] data_wr_slv2,
   input  logic [7:0] data_rd_slv2,
   input  logic [6:0] addr_slv2,
   output logic       done_slv2
);

   localparam logic [15:0] Q0 = quarter_count(SYS_CLK, DATA_RATE0);
   localparam logic [15:0] Q1 = quarter_count(SYS_CLK, DATA_RATE1);
   localparam logic [15:0] Q2 = quarter_count(SYS_CLK, DATA_RATE2);
   localparam logic [15:0] Q3 = quarter_count(SYS_CLK, DATA_RATE3);

   m_state_t    state;
   logic [15:0] q_sel;
   logic [15:0] qlen;
   logic [15:0] cnt;
   logic [1:0]  q;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic [7:0]  data_l;
   logic [7:0]  rd_sh;
   logic        rd_dir;
   logic        addr_acked;
   logic        ack_bit;
   logic        scl_m;
   logic        sda_m;
   logic        sda_s1;
   logic        sda_s2;
   logic        scl;
   logic        sda;

   assign scl = scl_m;
   assign sda = sda_m & sda_s1 & sda_s2;

   always_comb begin
      q_sel = Q3;
      case (speed_mode)
         SPD_STD:       q_sel = Q0;
         SPD_FAST:      q_sel = Q1;
         SPD_FAST_PLUS: q_sel = Q2;
         default:       q_sel = Q3;
      endcase
   end

   // Quarter q0-q1 holds SCL low, q2-q3 high; SDA changes on entry to q0, sampling on entry to q3.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= M_IDLE;
         qlen       <= Q0;
         cnt        <= '0;
         q          <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         data_l     <= '0;
         rd_sh      <= '0;
         rd_dir     <= 1'b0;
         addr_acked <= 1'b0;
         ack_bit    <= 1'b1;
         scl_m      <= 1'b1;
         sda_m      <= 1'b1;
         data_rd    <= '0;
         done       <= 1'b0;
         ack_error  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == M_IDLE) begin
            cnt <= '0;
            q   <= '0;
            if (write || read) begin
               state      <= M_START;
               rd_dir     <= ~write;
               shreg      <= {addr, ~write};
               data_l     <= data_wr;
               qlen       <= q_sel;
               ack_error  <= 1'b0;
               addr_acked <= 1'b0;
            end
         end else if (cnt != qlen - 16'd1) begin
            cnt <= cnt + 16'd1;
         end else begin
            cnt <= '0;
            q   <= q + 2'd1;
            case (q)
               2'd1: begin
                  scl_m <= 1'b1;
                  if (state == M_START) sda_m <= 1'b0;
               end
               2'd2: begin
                  ack_bit <= sda;
                  if (state == M_RDATA) rd_sh <= {rd_sh[6:0], sda};
                  if (state == M_STOP)  sda_m <= 1'b1;
               end
               2'd3: begin
                  scl_m <= 1'b0;
                  case (state)
                     M_START: begin
                        state   <= M_ADDR;
                        bit_idx <= 3'd7;
                        sda_m   <= shreg[7];
                     end
                     M_ADDR, M_WDATA: begin
                        if (bit_idx == 3'd0) begin
                           state <= (state == M_ADDR) ? M_ADDR_ACK : M_WACK;
                           sda_m <= 1'b1;
                        end else begin
                           bit_idx <= bit_idx - 3'd1;
                           shreg   <= {shreg[6:0], 1'b0};
                           sda_m   <= shreg[6];
                        end
                     end
                     M_ADDR_ACK: begin
                        if (ack_bit) begin
                           ack_error <= 1'b1;
                           state     <= M_STOP;
                           sda_m     <= 1'b0;
                        end else begin
                           addr_acked <= 1'b1;
                           bit_idx    <= 3'd7;
                           if (rd_dir) begin
                              state <= M_RDATA;
                              sda_m <= 1'b1;
                           end else begin
                              state <= M_WDATA;
                              shreg <= data_l;
                              sda_m <= data_l[7];
                           end
                        end
                     end
                     M_WACK: begin
                        ack_error <= ack_bit;
                        state     <= M_STOP;
                        sda_m     <= 1'b0;
                     end
                     M_RDATA: begin
                        if (bit_idx == 3'd0) begin
                           state <= M_MNACK;
                           sda_m <= 1'b1;
                        end else begin
                           bit_idx <= bit_idx - 3'd1;
                        end
                     end
                     M_MNACK: begin
                        state <= M_STOP;
                        sda_m <= 1'b0;
                     end
                     M_STOP: begin
                        state <= M_IDLE;
                        scl_m <= 1'b1;
                        sda_m <= 1'b1;
                        done  <= 1'b1;
                        if (rd_dir && addr_acked) data_rd <= rd_sh;
                     end
                     default: state <= M_IDLE;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   i2c_slave u_slv1 (
      .clk         (clk),
      .rst         (rst),
      .scl         (scl),
      .sda         (sda),
      .addr_slv    (addr_slv1),
      .data_rd_slv (data_rd_slv1),
      .data_wr_slv (data_wr_slv1),
      .done_slv    (done_slv1),
      .sda_drv     (sda_s1)
   );

   i2c_slave u_slv2 (
      .clk         (clk),
      .rst         (rst),
      .scl         (scl),
      .sda         (sda),
      .addr_slv    (addr_slv2),
      .data_rd_slv (data_rd_slv2),
      .data_wr_slv (data_wr_slv2),
      .done_slv    (done_slv2),
      .sda_drv     (sda_s2)
   );

endmodule

// File: tb/tb_i2c_test.sv
// tb/tb_i2c_test.sv - scoreboard bench for the i2c_test loopback subsystem
module tb_i2c_test;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       write = 1'b0;
   logic       read = 1'b0;
   logic [1:0] speed_mode = 2'b10;
   logic [6:0] addr = '0;
   logic [7:0] data_wr = '0;
   logic [7:0] data_rd;
   logic       done;
   logic       ack_error;
   logic [7:0] data_wr_slv1;
   logic [7:0] data_rd_slv1 = 8'h59;
   logic [6:0] addr_slv1 = 7'h19;
   logic       done_slv1;
   logic [7:0] data_wr_slv2;
   logic [7:0] data_rd_slv2 = 8'h3C;
   logic [6:0] addr_slv2 = 7'h1D;
   logic       done_slv2;

   always #5 clk = ~clk;

   i2c_test dut (
      .clk          (clk),
      .rst          (rst),
      .write        (write),
      .read         (read),
      .speed_mode   (speed_mode),
      .addr         (addr),
      .data_wr      (data_wr),
      .data_rd      (data_rd),
      .done         (done),
      .ack_error    (ack_error),
      .data_wr_slv1 (data_wr_slv1),
      .data_rd_slv1 (data_rd_slv1),
      .addr_slv1    (addr_slv1),
      .done_slv1    (done_slv1),
      .data_wr_slv2 (data_wr_slv2),
      .data_rd_slv2 (data_rd_slv2),
      .addr_slv2    (addr_slv2),
      .done_slv2    (done_slv2)
   );

   typedef struct {
      logic [7:0] rd;
      logic       ack;
      logic [7:0] wr1;
      logic [7:0] wr2;
      int         p1;
      int         p2;
      int         lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   p1_cnt = 0;
   int   p2_cnt = 0;
   int   elapsed;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts slave pulses and scores every master done against the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         p1_cnt = 0;
         p2_cnt = 0;
      end else begin
         if (done_slv1) p1_cnt++;
         if (done_slv2) p2_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("data_rd", data_rd, mon_e.rd);
               check("ack_error", ack_error, mon_e.ack);
               check("data_wr_slv1", data_wr_slv1, mon_e.wr1);
               check("data_wr_slv2", data_wr_slv2, mon_e.wr2);
               check("done_slv1_pulses", p1_cnt, mon_e.p1);
               check("done_slv2_pulses", p2_cnt, mon_e.p2);
               elapsed = cyc - start_cyc - 1;
               checks++;
               if (elapsed < mon_e.lat - 2 || elapsed > mon_e.lat + 2) begin
                  failures++;
                  $display("FAIL latency: got %0d clk expected %0d clk", elapsed, mon_e.lat);
               end
               p1_cnt = 0;
               p2_cnt = 0;
            end
         end
      end
   end

   task automatic issue(input logic w, input logic r, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] erd, input logic eack, input logic [7:0] ew1,
                        input logic [7:0] ew2, input int ep1, input int ep2, input int elat);
      exp_t e;
      e.rd = erd; e.ack = eack; e.wr1 = ew1; e.wr2 = ew2;
      e.p1 = ep1; e.p2 = ep2; e.lat = elat;
      @(negedge clk);
      addr = a; data_wr = d; write = w; read = r;
      start_cyc = cyc;
      sb.push_back(e);
      @(negedge clk);
      write = 1'b0; read = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("done_timeout", 32'd0, 32'd1);
         sb.delete();
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic run(input logic w, input logic r, input logic [6:0] a, input logic [7:0] d,
                      input logic [7:0] erd, input logic eack, input logic [7:0] ew1,
                      input logic [7:0] ew2, input int ep1, input int ep2, input int elat);
      issue(w, r, a, d, erd, eack, ew1, ew2, ep1, ep2, elat);
      wait_idle(elat + 500);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_data_rd"}, data_rd, 8'h00);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_ack_error"}, ack_error, 1'b0);
      check({tag, "_wr_slv1"}, data_wr_slv1, 8'h00);
      check({tag, "_wr_slv2"}, data_wr_slv2, 8'h00);
      check({tag, "_done_slv1"}, done_slv1, 1'b0);
      check({tag, "_done_slv2"}, done_slv2, 1'b0);
      check({tag, "_scl"}, dut.scl, 1'b1);
      check({tag, "_sda"}, dut.sda, 1'b1);
   endtask

   initial begin
      int   r1;
      int   r2;
      logic prev;
      repeat (10000) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b1;
      repeat (10) @(negedge clk);

      //   w     r     addr   data   rd     ack   wr1    wr2    p1 p2 latency
      run(1'b1, 1'b0, 7'h19, 8'h59, 8'h00, 1'b0, 8'h59, 8'h00, 1, 0, 2000);
      run(1'b0, 1'b1, 7'h19, 8'h00, 8'h59, 1'b0, 8'h59, 8'h00, 1, 0, 2000);
      run(1'b0, 1'b1, 7'h1D, 8'h00, 8'h3C, 1'b0, 8'h59, 8'h00, 0, 1, 2000);
      run(1'b1, 1'b0, 7'h1D, 8'hA3, 8'h3C, 1'b0, 8'h59, 8'hA3, 0, 1, 2000);
      run(1'b1, 1'b0, 7'h7F, 8'h55, 8'h3C, 1'b1, 8'h59, 8'hA3, 0, 0, 1100);
      run(1'b0, 1'b1, 7'h7F, 8'h00, 8'h3C, 1'b1, 8'h59, 8'hA3, 0, 0, 1100);
      run(1'b1, 1'b1, 7'h19, 8'h6E, 8'h3C, 1'b0, 8'h6E, 8'hA3, 1, 0, 2000);

      speed_mode = 2'b00;
      issue(1'b1, 1'b0, 7'h19, 8'h2B, 8'h3C, 1'b0, 8'h2B, 8'hA3, 1, 0, 20000);
      r1 = -1; r2 = -1; prev = dut.scl;
      for (int i = 0; i < 5000 && r2 < 0; i++) begin
         @(negedge clk);
         if (dut.scl && !prev) begin
            if (r1 < 0) r1 = cyc;
            else r2 = cyc;
         end
         prev = dut.scl;
      end
      if (r2 < 0) check("scl_rise_timeout", 32'd0, 32'd1);
      else check("scl_period_mode0", r2 - r1, 1000);
      wait_idle(20500);

      speed_mode = 2'b01;
      data_rd_slv1 = 8'hA5;
      run(1'b0, 1'b1, 7'h19, 8'h00, 8'hA5, 1'b0, 8'h2B, 8'hA3, 1, 0, 4960);
      speed_mode = 2'b11;
      run(1'b1, 1'b0, 7'h1D, 8'h81, 8'hA5, 1'b0, 8'h2B, 8'h81, 0, 1, 560);

      speed_mode = 2'b10;
      issue(1'b1, 1'b0, 7'h19, 8'h11, 8'h00, 1'b0, 8'h11, 8'h81, 1, 0, 2000);
      repeat (1200) @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_state("abort");
      sb.delete();
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      run(1'b1, 1'b0, 7'h19, 8'hC4, 8'h00, 1'b0, 8'hC4, 8'h00, 1, 0, 2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
